// File: rtl/branch_retire_queue_pkg.sv
// Shared types and constants for the retire branch-update queue.
// Optional coalescing is enabled by defining BRQ_COALESCE_EN.
package branch_retire_queue_pkg;

    localparam int BRQ_ADDR_WIDTH = 32;
    localparam int BRQ_DEPTH      = 8;

    typedef struct packed {
        logic [BRQ_ADDR_WIDTH-1:0] pc;
        logic [BRQ_ADDR_WIDTH-1:0] target;
        logic                      taken;
    } brq_entry_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/branch_retire_queue_if.sv
// Retire branch-update channel from the commit side to the fetch BTB.
// The BTB always accepts, so there is no ready signal.
interface retire_if
    import branch_retire_queue_pkg::*;
#(
    parameter int ADDR_WIDTH = BRQ_ADDR_WIDTH
);
    logic                  retire_branch_valid;
    logic [ADDR_WIDTH-1:0] update_btb_pc;
    logic [ADDR_WIDTH-1:0] update_btb_target;
    logic                  update_btb_taken;

    modport retire_branch_source (
        output retire_branch_valid,
        output update_btb_pc,
        output update_btb_target,
        output update_btb_taken
    );

    modport retire_branch_sink (
        input retire_branch_valid,
        input update_btb_pc,
        input update_btb_target,
        input update_btb_taken
    );
endinterface

// File: rtl/branch_retire_queue_fifo.sv
// Generic 2-write/1-read circular FIFO; writes are pre-compacted.
// Pointers carry an extra wrap bit so full and empty are distinct.
module brq_fifo_2w1r
    import branch_retire_queue_pkg::*;
#(
    parameter type T      = brq_entry_t,
    parameter int  DEPTH  = BRQ_DEPTH,
    localparam int IW     = $clog2(DEPTH),
    localparam int PW     = IW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    i_wr_cnt,
    input  T              i_wr_data [2],
    input  logic          i_rd_en,
    output T              o_rd_data,
    output logic          o_empty,
    output logic          o_full,
    output logic [PW-1:0] o_count
);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [IW-1:0] w_tidx;
    logic [IW-1:0] w_tidx1;

    assign w_tidx  = r_tail[IW-1:0];
    assign w_tidx1 = w_tidx + IW'(1);

    // Write up to two compacted entries at tail and tail+1.
    always_ff @(posedge clk) begin
        if (i_wr_cnt != 2'd0) r_mem[w_tidx] <= i_wr_data[0];
        if (i_wr_cnt == 2'd2) r_mem[w_tidx1] <= i_wr_data[1];
    end

    // Advance tail by the write count and head by one per read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_tail <= r_tail + PW'(i_wr_cnt);
            r_head <= r_head + PW'(i_rd_en);
        end
    end

    assign o_rd_data = r_mem[r_head[IW-1:0]];
    assign o_empty   = (r_head == r_tail);
    assign o_full    = (r_head[IW-1:0] == r_tail[IW-1:0]) &&
                       (r_head[IW] != r_tail[IW]);
    assign o_count   = r_tail - r_head;

endmodule

// File: rtl/branch_retire_queue.sv
// Collects up to two retired branches per cycle and emits one BTB update.
// Define BRQ_COALESCE_EN to drop an older same-set branch in a dual retire.
module branch_retire_queue
    import branch_retire_queue_pkg::*;
#(
    parameter int  ADDR_WIDTH  = BRQ_ADDR_WIDTH,
    parameter int  DEPTH       = BRQ_DEPTH,
    parameter int  BTB_ENTRIES = 16,
    parameter int  BTB_WIDTH   = $clog2(BTB_ENTRIES),
    localparam int PW          = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                commit_br_valid,
    input  logic [1:0][ADDR_WIDTH-1:0] commit_br_pc,
    input  logic [1:0][ADDR_WIDTH-1:0] commit_br_target,
    input  logic [1:0]                commit_br_taken,
    output logic                      commit_ready,
    output logic [PW-1:0]             occupancy,
    output logic                      overflow_err,
    retire_if.retire_branch_source    retire_branch_bus
);

`ifdef BRQ_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] target;
        logic                  taken;
    } entry_t;

    entry_t        w_lane [2];
    entry_t        w_wr_data [2];
    entry_t        w_rd;
    logic [1:0]    w_v;
    logic [1:0]    w_wr_cnt;
    logic          w_same_set;
    logic          w_empty;
    logic          w_full;
    logic          r_overflow;

    assign w_same_set = (commit_br_pc[0][BTB_WIDTH+1:2] ==
                         commit_br_pc[1][BTB_WIDTH+1:2]);

    assign commit_ready = !w_full && (occupancy <= PW'(DEPTH - 2));

    // Coalesce same-set pairs, then compact valid lanes oldest first.
    always_comb begin
        w_lane[0] = '{commit_br_pc[0], commit_br_target[0],
                      commit_br_taken[0]};
        w_lane[1] = '{commit_br_pc[1], commit_br_target[1],
                      commit_br_taken[1]};
        w_v = commit_br_valid;
        if (COALESCE && (&commit_br_valid) && w_same_set) w_v = 2'b10;
        w_wr_data[0] = w_v[0] ? w_lane[0] : w_lane[1];
        w_wr_data[1] = w_lane[1];
        w_wr_cnt     = commit_ready ? popcount2(w_v) : 2'd0;
    end

    brq_fifo_2w1r #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_cnt  (w_wr_cnt),
        .i_wr_data (w_wr_data),
        .i_rd_en   (!w_empty),
        .o_rd_data (w_rd),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_count   (occupancy)
    );

    // Sticky flag: a branch was offered while the queue could not take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_overflow <= 1'b0;
        else if ((|commit_br_valid) && !commit_ready) r_overflow <= 1'b1;
    end

    assign overflow_err = r_overflow;

    assign retire_branch_bus.retire_branch_valid = !w_empty;
    assign retire_branch_bus.update_btb_pc       = w_empty ? '0 : w_rd.pc;
    assign retire_branch_bus.update_btb_target   = w_empty ? '0 : w_rd.target;
    assign retire_branch_bus.update_btb_taken    = !w_empty && w_rd.taken;

endmodule

// File: tb/tb_branch_retire_queue.sv
// Directed-vector bench for branch_retire_queue (DEPTH=8, BTB_ENTRIES=16).
// Build with +define+BRQ_COALESCE_EN to exercise the coalescing variant.
module tb_branch_retire_queue;

    logic             clk;
    logic             rst_n;
    logic [1:0]       commit_br_valid;
    logic [1:0][31:0] commit_br_pc;
    logic [1:0][31:0] commit_br_target;
    logic [1:0]       commit_br_taken;
    logic             commit_ready;
    logic [3:0]       occupancy;
    logic             overflow_err;

    int n_vec  = 0;
    int n_miss = 0;

    retire_if #(.ADDR_WIDTH(32)) bus ();

    branch_retire_queue #(
        .ADDR_WIDTH  (32),
        .DEPTH       (8),
        .BTB_ENTRIES (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .commit_br_valid   (commit_br_valid),
        .commit_br_pc      (commit_br_pc),
        .commit_br_target  (commit_br_target),
        .commit_br_taken   (commit_br_taken),
        .commit_ready      (commit_ready),
        .occupancy         (occupancy),
        .overflow_err      (overflow_err),
        .retire_branch_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v,
                         input logic [31:0] p0, input logic [31:0] t0,
                         input logic k0,
                         input logic [31:0] p1, input logic [31:0] t1,
                         input logic k1);
        commit_br_valid     = v;
        commit_br_pc[0]     = p0;
        commit_br_target[0] = t0;
        commit_br_taken[0]  = k0;
        commit_br_pc[1]     = p1;
        commit_br_target[1] = t1;
        commit_br_taken[1]  = k1;
    endtask

    task automatic idle();
        drive(2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        n_vec++;
        if ({bus.retire_branch_valid, occupancy, commit_ready, overflow_err}
            !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
            n_miss++;
            $display("FAIL reset_hold: got v/occ/rdy/ovf=%b exp 0_0000_1_0",
                {bus.retire_branch_valid, occupancy, commit_ready,
                 overflow_err});
        end
        rst_n = 1'b1;
        drive(2'b11, 32'h10, 32'h20, 1'b1, 32'h14, 32'h24, 1'b0);
        tick();
        tick();
        idle();
        n_vec++;
        if (occupancy !== 4'd3) begin
            n_miss++;
            $display("FAIL reset_prefill_occ: got %0d exp 3", occupancy);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.retire_branch_valid, occupancy, commit_ready, overflow_err}
            !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
            n_miss++;
            $display("FAIL reset_async: got v/occ/rdy/ovf=%b exp 0_0000_1_0",
                {bus.retire_branch_valid, occupancy, commit_ready,
                 overflow_err});
        end
        n_vec++;
        if ({bus.update_btb_pc, bus.update_btb_target, bus.update_btb_taken}
            !== 65'd0) begin
            n_miss++;
            $display("FAIL reset_bus: got pc=%h tgt=%h tk=%b exp 0",
                bus.update_btb_pc, bus.update_btb_target,
                bus.update_btb_taken);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if ({bus.retire_branch_valid, occupancy, commit_ready, overflow_err,
             bus.update_btb_pc} !== {1'b0, 4'd0, 1'b1, 1'b0, 32'h0}) begin
            n_miss++;
            $display("FAIL reset_release: got v=%b occ=%0d rdy=%b pc=%h exp 0 0 1 0",
                bus.retire_branch_valid, occupancy, commit_ready,
                bus.update_btb_pc);
        end
    endtask

    task automatic test_single();
        drive(2'b01, 32'h100, 32'h200, 1'b1, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        n_vec++;
        if ({bus.retire_branch_valid, bus.update_btb_pc,
             bus.update_btb_target, bus.update_btb_taken, occupancy}
            !== {1'b1, 32'h100, 32'h200, 1'b1, 4'd1}) begin
            n_miss++;
            $display("FAIL single_present: got v=%b pc=%h tgt=%h tk=%b occ=%0d exp 1 100 200 1 1",
                bus.retire_branch_valid, bus.update_btb_pc,
                bus.update_btb_target, bus.update_btb_taken, occupancy);
        end
        tick();
        n_vec++;
        if ({bus.retire_branch_valid, occupancy} !== {1'b0, 4'd0}) begin
            n_miss++;
            $display("FAIL single_drain: got v=%b occ=%0d exp 0 0",
                bus.retire_branch_valid, occupancy);
        end
    endtask

    task automatic test_dual();
        drive(2'b11, 32'h40, 32'h80, 1'b1, 32'h44, 32'h48, 1'b0);
        tick();
        idle();
        n_vec++;
        if ({bus.retire_branch_valid, bus.update_btb_pc,
             bus.update_btb_target, bus.update_btb_taken, occupancy}
            !== {1'b1, 32'h40, 32'h80, 1'b1, 4'd2}) begin
            n_miss++;
            $display("FAIL dual_lane0: got v=%b pc=%h tgt=%h tk=%b occ=%0d exp 1 40 80 1 2",
                bus.retire_branch_valid, bus.update_btb_pc,
                bus.update_btb_target, bus.update_btb_taken, occupancy);
        end
        tick();
        n_vec++;
        if ({bus.retire_branch_valid, bus.update_btb_pc,
             bus.update_btb_target, bus.update_btb_taken, occupancy}
            !== {1'b1, 32'h44, 32'h48, 1'b0, 4'd1}) begin
            n_miss++;
            $display("FAIL dual_lane1: got v=%b pc=%h tgt=%h tk=%b occ=%0d exp 1 44 48 0 1",
                bus.retire_branch_valid, bus.update_btb_pc,
                bus.update_btb_target, bus.update_btb_taken, occupancy);
        end
        tick();
        n_vec++;
        if ({bus.retire_branch_valid, occupancy} !== {1'b0, 4'd0}) begin
            n_miss++;
            $display("FAIL dual_drain: got v=%b occ=%0d exp 0 0",
                bus.retire_branch_valid, occupancy);
        end
    endtask

    task automatic test_lane1_only();
        drive(2'b10, 32'hBAD0, 32'hBAD4, 1'b1, 32'h300, 32'h340, 1'b1);
        tick();
        idle();
        n_vec++;
        if ({bus.retire_branch_valid, bus.update_btb_pc,
             bus.update_btb_target, occupancy}
            !== {1'b1, 32'h300, 32'h340, 4'd1}) begin
            n_miss++;
            $display("FAIL lane1_only: got v=%b pc=%h tgt=%h occ=%0d exp 1 300 340 1",
                bus.retire_branch_valid, bus.update_btb_pc,
                bus.update_btb_target, occupancy);
        end
        tick();
    endtask

    task automatic test_fill_wrap();
        int e;
        e = 0;
        for (int c = 0; c < 6; c++) begin
            n_vec++;
            if (commit_ready !== 1'b1) begin
                n_miss++;
                $display("FAIL fill_ready[%0d]: got %b exp 1", c, commit_ready);
            end
            drive(2'b11, 32'h1000 + 32'(8 * c), 32'h11000 + 32'(8 * c), 1'b1,
                  32'h1004 + 32'(8 * c), 32'h11004 + 32'(8 * c), 1'b0);
            tick();
            n_vec++;
            if ({bus.retire_branch_valid, bus.update_btb_pc,
                 bus.update_btb_target, bus.update_btb_taken}
                !== {1'b1, 32'h1000 + 32'(4 * e), 32'h11000 + 32'(4 * e),
                     1'(e % 2 == 0)}) begin
                n_miss++;
                $display("FAIL fill_out[%0d]: got v=%b pc=%h tk=%b exp pc=%h",
                    e, bus.retire_branch_valid, bus.update_btb_pc,
                    bus.update_btb_taken, 32'h1000 + 32'(4 * e));
            end
            e++;
        end
        idle();
        n_vec++;
        if ({occupancy, commit_ready} !== {4'd7, 1'b0}) begin
            n_miss++;
            $display("FAIL fill_full: got occ=%0d rdy=%b exp 7 0",
                occupancy, commit_ready);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            n_vec++;
            if (e < 12) begin
                if ({bus.retire_branch_valid, bus.update_btb_pc,
                     bus.update_btb_taken}
                    !== {1'b1, 32'h1000 + 32'(4 * e), 1'(e % 2 == 0)}) begin
                    n_miss++;
                    $display("FAIL wrap_out[%0d]: got v=%b pc=%h exp pc=%h",
                        e, bus.retire_branch_valid, bus.update_btb_pc,
                        32'h1000 + 32'(4 * e));
                end
                e++;
            end else if (bus.retire_branch_valid !== 1'b0) begin
                n_miss++;
                $display("FAIL wrap_empty: got v=%b exp 0",
                    bus.retire_branch_valid);
            end
        end
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 6; c++) begin
            drive(2'b11, 32'h2000 + 32'(8 * c), 32'h0, 1'b1,
                  32'h2004 + 32'(8 * c), 32'h0, 1'b0);
            tick();
        end
        n_vec++;
        if ({commit_ready, overflow_err} !== {1'b0, 1'b0}) begin
            n_miss++;
            $display("FAIL ovf_pre: got rdy=%b ovf=%b exp 0 0",
                commit_ready, overflow_err);
        end
        drive(2'b01, 32'hDEAD0, 32'hDEAD4, 1'b1, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        n_vec++;
        if ({occupancy, overflow_err} !== {4'd6, 1'b1}) begin
            n_miss++;
            $display("FAIL ovf_set: got occ=%0d ovf=%b exp 6 1",
                occupancy, overflow_err);
        end
        tick();
        n_vec++;
        if ({occupancy, overflow_err} !== {4'd5, 1'b1}) begin
            n_miss++;
            $display("FAIL ovf_sticky: got occ=%0d ovf=%b exp 5 1",
                occupancy, overflow_err);
        end
        for (int e = 7; e < 12; e++) begin
            n_vec++;
            if ({bus.retire_branch_valid, bus.update_btb_pc}
                !== {1'b1, 32'h2000 + 32'(4 * e)}) begin
                n_miss++;
                $display("FAIL ovf_drain[%0d]: got v=%b pc=%h exp pc=%h",
                    e, bus.retire_branch_valid, bus.update_btb_pc,
                    32'h2000 + 32'(4 * e));
            end
            tick();
        end
        n_vec++;
        if ({bus.retire_branch_valid, overflow_err} !== {1'b0, 1'b1}) begin
            n_miss++;
            $display("FAIL ovf_end: got v=%b ovf=%b exp 0 1",
                bus.retire_branch_valid, overflow_err);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (overflow_err !== 1'b0) begin
            n_miss++;
            $display("FAIL ovf_clear: got %b exp 0", overflow_err);
        end
    endtask

    task automatic test_coalesce();
        drive(2'b11, 32'h104, 32'h500, 1'b1, 32'h144, 32'h600, 1'b0);
        tick();
        idle();
`ifdef BRQ_COALESCE_EN
        n_vec++;
        if ({bus.retire_branch_valid, bus.update_btb_pc,
             bus.update_btb_target, bus.update_btb_taken, occupancy}
            !== {1'b1, 32'h144, 32'h600, 1'b0, 4'd1}) begin
            n_miss++;
            $display("FAIL coal_young: got v=%b pc=%h tgt=%h occ=%0d exp 1 144 600 1",
                bus.retire_branch_valid, bus.update_btb_pc,
                bus.update_btb_target, occupancy);
        end
`else
        n_vec++;
        if ({bus.retire_branch_valid, bus.update_btb_pc,
             bus.update_btb_target, bus.update_btb_taken, occupancy}
            !== {1'b1, 32'h104, 32'h500, 1'b1, 4'd2}) begin
            n_miss++;
            $display("FAIL nocoal_old: got v=%b pc=%h tgt=%h occ=%0d exp 1 104 500 2",
                bus.retire_branch_valid, bus.update_btb_pc,
                bus.update_btb_target, occupancy);
        end
        tick();
        n_vec++;
        if ({bus.retire_branch_valid, bus.update_btb_pc,
             bus.update_btb_target, bus.update_btb_taken}
            !== {1'b1, 32'h144, 32'h600, 1'b0}) begin
            n_miss++;
            $display("FAIL nocoal_young: got v=%b pc=%h tgt=%h exp 1 144 600",
                bus.retire_branch_valid, bus.update_btb_pc,
                bus.update_btb_target);
        end
`endif
        tick();
        n_vec++;
        if (bus.retire_branch_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL coal_drain: got v=%b exp 0",
                bus.retire_branch_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_single();
        test_dual();
        test_lane1_only();
        test_coalesce();
        test_fill_wrap();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
